// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, frame constants, default bit period.
// UART_RX_PARITY_EN adds the PARITY state to the rx encoding.
package uart_pkg;

    localparam int       DATA_BITS           = 8;
    localparam logic     IDLE_LEVEL          = 1'b1;
    localparam int       DEFAULT_CLK_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY    = 3'd5
`endif
    } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter: half-period load on request, full-period
// reload whenever it reaches zero while running. Shared with the transmitter.
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_half_i,
    input  logic run_i,
    output logic zero_o
);

    localparam int              CNT_W   = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_half_i) begin
            cnt_q <= HALF_M1;
        end else if (run_i) begin
            cnt_q <= (cnt_q == '0) ? FULL_M1 : cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 receive framer with mid-bit sampling and valid/ready byte delivery.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | half a bit into the start bit, confirm it is still low
// DATA      | sampling the 8 data bits, LSB first
// PARITY    | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_sync,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int                 IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 overrun_q;
    logic                 load_half;
    logic                 run;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 par_err_q, par_err_d;
`endif

    uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_half_i (load_half),
        .run_i       (run),
        .zero_o      (tick)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        load_half   = 1'b0;
        run         = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_sync != IDLE_LEVEL) begin
                    state_d   = ST_START;
                    load_half = 1'b1;
                end
            end
            ST_START: begin
                run = 1'b1;
                if (tick) begin
                    if (rx_sync != IDLE_LEVEL) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                run = 1'b1;
                if (tick) begin
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                run = 1'b1;
                if (tick) begin
                    par_bad_d = ^{shift_q, rx_sync};
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                run = 1'b1;
                if (tick) begin
`ifdef UART_RX_PARITY_EN
                    par_err_d = par_bad_q;
`endif
                    if (rx_sync == IDLE_LEVEL) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // a held-low break must not look like a fresh start bit
                if (rx_sync == IDLE_LEVEL) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    // A completing byte wins over acceptance; overrun only if it was not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (done_q) begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
            overrun_q  <= rx_valid_q && !rx_ready;
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at CLK_PER_BIT=4 (default 8N1 build).
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_sync;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    int         pe_cnt    = 0;
    int         vrise_cnt = 0;
    int         vhigh_cnt = 0;
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         rise_pe   = 0;
    logic [7:0] rise_data = 8'h00;
    logic       prev_valid = 1'b0;

    uart_rx_frame #(.CLK_PER_BIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_sync   (rx_sync),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // event monitor, sampled 2 time units after each rising edge
    always @(posedge clk) begin
        pe_cnt++;
        #2;
        if (rx_valid && !prev_valid) begin
            vrise_cnt++;
            rise_pe   = pe_cnt;
            rise_data = rx_data;
        end
        if (rx_valid)  vhigh_cnt++;
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
        prev_valid = rx_valid;
    end

    task automatic send_bit(input logic v);
        rx_sync = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        rx_sync  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_a5;
        int v0, h0, f0, o0, s0;
        rx_ready = 1'b1;
        v0 = vrise_cnt; h0 = vhigh_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        s0 = pe_cnt;
        send_frame(8'hA5, 1'b1);
        repeat (6) @(negedge clk);
        total++; if (rise_pe - s0 !== 40) begin bad++; $display("FAIL a5_latency: got %0d want 40", rise_pe - s0); end
        total++; if (rise_data !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", rise_data); end
        total++; if (vrise_cnt - v0 !== 1) begin bad++; $display("FAIL a5_nvalid: got %0d want 1", vrise_cnt - v0); end
        total++; if (vhigh_cnt - h0 !== 1) begin bad++; $display("FAIL a5_valid_width: got %0d want 1", vhigh_cnt - h0); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL a5_ferr: got %0d want 0", ferr_cnt - f0); end
        total++; if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL a5_ovr: got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_false_start;
        int v0, f0;
        v0 = vrise_cnt; f0 = ferr_cnt;
        rx_sync = 1'b0;
        @(negedge clk);
        rx_sync = 1'b1;
        repeat (60) @(negedge clk);
        total++; if (vrise_cnt - v0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", vrise_cnt - v0); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid_lvl: got %b want 0", rx_valid); end
    endtask

    task automatic test_break;
        int v0, f0, o0;
        v0 = vrise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h3C, 1'b0);
        total++; if (vrise_cnt - v0 !== 0) begin bad++; $display("FAIL brk_no_3c: got %0d want 0", vrise_cnt - v0); end
        repeat (40) @(negedge clk);
        rx_sync = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL brk_ferr: got %0d want 1", ferr_cnt - f0); end
        total++; if (vrise_cnt - v0 !== 1) begin bad++; $display("FAIL brk_nvalid: got %0d want 1", vrise_cnt - v0); end
        total++; if (rise_data !== 8'h81) begin bad++; $display("FAIL brk_data: got %h want 81", rise_data); end
        total++; if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL brk_ovr: got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_overrun;
        int v0, o0;
        rx_ready = 1'b0;
        v0 = vrise_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_first_data: got %h want 11", rx_data); end
        send_frame(8'h22, 1'b1);
        repeat (3) @(negedge clk);
        total++; if (ovr_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0); end
        total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL ovr_data: got %h want 22", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        total++; if (vrise_cnt - v0 !== 1) begin bad++; $display("FAIL ovr_nrise: got %0d want 1", vrise_cnt - v0); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", rx_valid); end
    endtask

    task automatic test_accept_same_edge;
        int o0;
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL acc_first_valid: got %b want 1", rx_valid); end
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (39) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL acc_data: got %h want 22", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL acc_valid: got %b want 1", rx_valid); end
        total++; if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL acc_ovr: got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_reset_mid;
        int v0, f0;
        rx_ready = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstm_data: got %h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstm_valid: got %b want 0", rx_valid); end
        repeat (3) @(negedge clk);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstm_ferr: got %b want 0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstm_ovr: got %b want 0", overrun); end
        rst_n = 1'b1;
        v0 = vrise_cnt; f0 = ferr_cnt;
        repeat (40) @(negedge clk);
        total++; if (vrise_cnt - v0 !== 0) begin bad++; $display("FAIL rstm_partial: got %0d want 0", vrise_cnt - v0); end
        send_frame(8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (vrise_cnt - v0 !== 1) begin bad++; $display("FAIL rstm_nvalid: got %0d want 1", vrise_cnt - v0); end
        total++; if (rise_data !== 8'h0F) begin bad++; $display("FAIL rstm_data_0f: got %h want 0f", rise_data); end
        total++; if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL rstm_ferr_cnt: got %0d want 0", ferr_cnt - f0); end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_sync  = 1'b1;
        rx_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic_a5;
        test_false_start;
        test_break;
        test_overrun;
        test_accept_same_edge;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
